traffic_ctrl_nway: RTL



---
 rtl/traffic_ctrl_nway.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_nway.sv
// rtl/traffic_ctrl_nway.sv - N-way round-robin intersection light controller
module traffic_ctrl_nway #(
   parameter int N_WAYS     = 4,
   parameter int TIMER_W    = 16,
   parameter int GREEN_MIN  = 2500,
   parameter int GREEN_MAX  = 7500,
   parameter int YELLOW_CYC = 1500,
   parameter int ALLRED_CYC = 500,
   parameter int FLASH_HALF = 250
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [N_WAYS-1:0]           sensor,
   input  logic                        flash,
   output logic [N_WAYS-1:0]           green,
   output logic [N_WAYS-1:0]           yellow,
   output logic [N_WAYS-1:0]           red,
   output logic [$clog2(N_WAYS)-1:0]   active,
   output logic                        new_green
);

   localparam int AW = $clog2(N_WAYS);

   localparam logic [1:0] S_GREEN  = 2'd0;
   localparam logic [1:0] S_YELLOW = 2'd1;
   localparam logic [1:0] S_ALLRED = 2'd2;
   localparam logic [1:0] S_FLASH  = 2'd3;

   // Terminal counts: cnt is 0 on the entry cycle, so a phase of L cycles ends at L-1
   localparam logic [TIMER_W-1:0] C_GMIN1   = TIMER_W'(GREEN_MIN - 1);
   localparam logic [TIMER_W-1:0] C_GMAX1   = TIMER_W'(GREEN_MAX - 1);
   localparam logic [TIMER_W-1:0] C_YELLOW1 = TIMER_W'(YELLOW_CYC - 1);
   localparam logic [TIMER_W-1:0] C_ALLRED1 = TIMER_W'(ALLRED_CYC - 1);
   localparam logic [TIMER_W-1:0] C_FLASH1  = TIMER_W'(FLASH_HALF - 1);
   localparam logic [TIMER_W-1:0] C_ONE     = TIMER_W'(1);

   logic [1:0]         r_state;
   logic [AW-1:0]      r_cur;
   logic [AW-1:0]      r_nxt;
   logic [TIMER_W-1:0] r_cnt;
   logic               r_fphase;
   logic               r_new_green;

   logic [N_WAYS-1:0]  w_cur_mask;
   logic               w_other_demand;
   logic               w_cur_demand;
   logic               w_green_exit;
   logic [AW-1:0]      w_succ;
   logic               w_found;

   assign w_cur_mask     = N_WAYS'(1) << r_cur;
   assign w_other_demand = |(sensor & ~w_cur_mask);
   assign w_cur_demand   = |(sensor & w_cur_mask);
   // Leave green once the minimum has run and someone else waits, unless our own flow continues below the maximum
   assign w_green_exit   = (r_cnt >= C_GMIN1) && w_other_demand &&
                           (!w_cur_demand || (r_cnt == C_GMAX1));

   // Circular search for the first waiting approach after the current one
   always_comb begin
      int j;
      j       = 0;
      w_succ  = '0;
      w_found = 1'b0;
      for (int k = 1; k < N_WAYS; k++) begin
         j = int'(r_cur) + k;
         if (j >= N_WAYS) j = j - N_WAYS;
         if (!w_found && sensor[j]) begin
            w_found = 1'b1;
            w_succ  = AW'(j);
         end
      end
   end

   // Phase sequencer: night mode overrides everything, otherwise green/yellow/all-red rotation
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_GREEN;
         r_cur       <= '0;
         r_nxt       <= '0;
         r_cnt       <= '0;
         r_fphase    <= 1'b0;
         r_new_green <= 1'b0;
      end else begin
         r_new_green <= 1'b0;
         if (flash) begin
            if (r_state != S_FLASH) begin
               r_state  <= S_FLASH;
               r_cnt    <= '0;
               r_fphase <= 1'b1;
            end else if (r_cnt == C_FLASH1) begin
               r_cnt    <= '0;
               r_fphase <= ~r_fphase;
            end else begin
               r_cnt <= r_cnt + C_ONE;
            end
         end else begin
            case (r_state)
               S_GREEN: begin
                  if (w_green_exit) begin
                     r_state <= S_YELLOW;
                     r_nxt   <= w_succ;
                     r_cnt   <= '0;
                  end else if (r_cnt != C_GMAX1) begin
                     r_cnt <= r_cnt + C_ONE;
                  end
               end
               S_YELLOW: begin
                  if (r_cnt == C_YELLOW1) begin
                     r_state <= S_ALLRED;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + C_ONE;
                  end
               end
               S_ALLRED: begin
                  if (r_cnt == C_ALLRED1) begin
                     r_state     <= S_GREEN;
                     r_cur       <= r_nxt;
                     r_cnt       <= '0;
                     r_new_green <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + C_ONE;
                  end
               end
               S_FLASH: begin
                  // Leaving night mode always restarts the rotation at approach 0
                  r_state  <= S_ALLRED;
                  r_nxt    <= '0;
                  r_cnt    <= '0;
                  r_fphase <= 1'b0;
               end
               default: begin
                  r_state <= S_GREEN;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   // Lamp decode from registered state only, so lamps never glitch on sensor changes
   always_comb begin
      green  = '0;
      yellow = '0;
      red    = '0;
      case (r_state)
         S_GREEN:  green  = w_cur_mask;
         S_YELLOW: yellow = w_cur_mask;
         S_FLASH:  yellow = {N_WAYS{r_fphase}};
         default:  ;
      endcase
      if (r_state != S_FLASH) red = ~(green | yellow);
   end

   assign active    = r_cur;
   assign new_green = r_new_green;

endmodule
